// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator for the oscilloscope display.
// The horizontal and vertical counters advance only on PIX_EN ticks.
// Sync, active and coordinate outputs are registered from one set of next-state
// values, so every output describes the same pixel with no skew between them.
// LINE_START / FRAME_START are single-clock pulses on the cycle after a tick.
module vga_timing_gen #(
  parameter int H_VIS  = 1280,
  parameter int H_FP   = 48,
  parameter int H_SYNC = 112,
  parameter int H_BP   = 248,
  parameter int V_VIS  = 1024,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 3,
  parameter int V_BP   = 38,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic        CLK_VGA,
  input  logic        RESET,
  input  logic        PIX_EN,
  output logic [11:0] VGA_horzCoord,
  output logic [11:0] VGA_vertCoord,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_ACTIVE,
  output logic        LINE_START,
  output logic        FRAME_START
);

  // Derived raster geometry, all sized to the 12-bit coordinate width.
  localparam int H_TOTAL_I = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL_I = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL_I - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL_I - 1);
  localparam logic [11:0] H_VIS_W  = 12'(H_VIS);
  localparam logic [11:0] V_VIS_W  = 12'(V_VIS);
  localparam logic [11:0] HS_BEG   = 12'(H_VIS + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_VIS + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG   = 12'(V_VIS + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_VIS + V_FP + V_SYNC);

  // Registered state and its next-state values.
  logic [11:0] horz_q, horz_d;
  logic [11:0] vert_q, vert_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        active_q, active_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  // Combinational helpers for the tick path.
  logic        h_wrap;
  logic        v_wrap;
  logic [11:0] horz_inc;
  logic [11:0] vert_inc;

  // Next-state: advance counters on a tick and derive all outputs from the new coordinate.
  always_comb begin
    horz_d        = horz_q;
    vert_d        = vert_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    active_d      = active_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    // ">=" rather than "==" so an out-of-range counter recovers on the next tick.
    h_wrap   = (horz_q >= H_LAST);
    v_wrap   = (vert_q >= V_LAST);
    horz_inc = horz_q + 12'd1;
    vert_inc = vert_q + 12'd1;

    if (PIX_EN) begin
      horz_d = h_wrap ? 12'd0 : horz_inc;
      if (h_wrap) begin
        vert_d = v_wrap ? 12'd0 : vert_inc;
      end

      // Sync and active come from horz_d/vert_d so they align with the coordinates.
      hs_d     = ((horz_d >= HS_BEG) && (horz_d < HS_END)) ? HS_POL : ~HS_POL;
      vs_d     = ((vert_d >= VS_BEG) && (vert_d < VS_END)) ? VS_POL : ~VS_POL;
      active_d = (horz_d < H_VIS_W) && (vert_d < V_VIS_W);

      line_start_d  = (horz_d == 12'd0);
      frame_start_d = (horz_d == 12'd0) && (vert_d == 12'd0);
    end
  end

  // State register: reset parks the raster on its last pixel so the first tick lands on (0,0).
  always_ff @(posedge CLK_VGA) begin
    if (RESET) begin
      horz_q        <= H_LAST;
      vert_q        <= V_LAST;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      horz_q        <= horz_d;
      vert_q        <= vert_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign VGA_horzCoord = horz_q;
  assign VGA_vertCoord = vert_q;
  assign VGA_HS        = hs_q;
  assign VGA_VS        = vs_q;
  assign VGA_ACTIVE    = active_q;
  assign LINE_START    = line_start_q;
  assign FRAME_START   = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a reduced-geometry instance checked cycle by
// cycle against a scoreboard, plus a default-geometry instance checked over
// reset, the first tick and one full line.
module tb_vga_timing_gen;

  // Reduced raster: 25 x 13, HS window 18..20 (negative polarity), VS window 9..10.
  localparam int SH_VIS = 16, SH_FP = 2, SH_SYNC = 3, SH_BP = 4;
  localparam int SV_VIS = 8,  SV_FP = 1, SV_SYNC = 2, SV_BP = 2;
  localparam int SH_TOT = 25, SV_TOT = 13;
  localparam bit S_HS_POL = 1'b0, S_VS_POL = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance signals
  logic        rst_s, en_s;
  logic [11:0] s_h, s_v;
  logic        s_hs, s_vs, s_act, s_ls, s_fs;

  // Default-geometry instance signals
  logic        rst_b, en_b;
  logic [11:0] b_h, b_v;
  logic        b_hs, b_vs, b_act, b_ls, b_fs;

  vga_timing_gen #(
    .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
    .HS_POL(S_HS_POL), .VS_POL(S_VS_POL)
  ) dut_small (
    .CLK_VGA(clk), .RESET(rst_s), .PIX_EN(en_s),
    .VGA_horzCoord(s_h), .VGA_vertCoord(s_v),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_ACTIVE(s_act),
    .LINE_START(s_ls), .FRAME_START(s_fs)
  );

  vga_timing_gen dut_big (
    .CLK_VGA(clk), .RESET(rst_b), .PIX_EN(en_b),
    .VGA_horzCoord(b_h), .VGA_vertCoord(b_v),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_ACTIVE(b_act),
    .LINE_START(b_ls), .FRAME_START(b_fs)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        hs;
    logic        vs;
    logic        act;
    logic        ls;
    logic        fs;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  int m_h, m_v;
  bit m_hs, m_vs, m_act, m_ls, m_fs;

  int cyc = 0;
  int last_fs = -1;
  int exp_period = 0;

  task automatic model_step(input bit en, input bit rst);
    if (rst) begin
      m_h = SH_TOT - 1; m_v = SV_TOT - 1;
      m_hs = !S_HS_POL; m_vs = !S_VS_POL;
      m_act = 1'b0; m_ls = 1'b0; m_fs = 1'b0;
    end else if (en) begin
      if (m_h == SH_TOT - 1) begin
        m_h = 0;
        m_v = (m_v == SV_TOT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
      m_hs  = (m_h >= SH_VIS + SH_FP && m_h < SH_VIS + SH_FP + SH_SYNC) ? S_HS_POL : !S_HS_POL;
      m_vs  = (m_v >= SV_VIS + SV_FP && m_v < SV_VIS + SV_FP + SV_SYNC) ? S_VS_POL : !S_VS_POL;
      m_act = (m_h < SH_VIS) && (m_v < SV_VIS);
      m_ls  = (m_h == 0);
      m_fs  = (m_h == 0) && (m_v == 0);
    end else begin
      m_ls = 1'b0;
      m_fs = 1'b0;
    end
  endtask

  // One small-instance transaction: drive, predict, push, then pop and compare after the edge.
  task automatic step(input bit en, input bit rst);
    exp_t e;
    @(negedge clk);
    rst_s = rst;
    en_s  = en;
    model_step(en, rst);
    e.h = 12'(m_h); e.v = 12'(m_v);
    e.hs = m_hs; e.vs = m_vs; e.act = m_act; e.ls = m_ls; e.fs = m_fs;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("horz", 32'(s_h), 32'(e.h));
      check_eq("vert", 32'(s_v), 32'(e.v));
      check_eq("hs", 32'(s_hs), 32'(e.hs));
      check_eq("vs", 32'(s_vs), 32'(e.vs));
      check_eq("active", 32'(s_act), 32'(e.act));
      check_eq("line_start", 32'(s_ls), 32'(e.ls));
      check_eq("frame_start", 32'(s_fs), 32'(e.fs));
    end
    $display("txn %0d rst=%0b en=%0b h=%0d v=%0d hs=%0b vs=%0b act=%0b ls=%0b fs=%0b",
             cyc, rst, en, s_h, s_v, s_hs, s_vs, s_act, s_ls, s_fs);
    if (rst) begin
      last_fs = -1;
    end else if (s_fs === 1'b1) begin
      if (exp_period > 0 && last_fs >= 0) check_eq("fs_period", 32'(cyc - last_fs), 32'(exp_period));
      last_fs = cyc;
    end
  endtask

  int hs_cnt, hs_first, hs_last, inact_cnt;

  initial begin
    rst_s = 1'b1; en_s = 1'b0;
    rst_b = 1'b1; en_b = 1'b1;

    // Default geometry: reset state
    @(negedge clk);
    rst_b = 1'b1; en_b = 1'b1;
    @(posedge clk); #1;
    check_eq("big_rst_horz", 32'(b_h), 32'd1687);
    check_eq("big_rst_vert", 32'(b_v), 32'd1065);
    check_eq("big_rst_hs", 32'(b_hs), 32'd0);
    check_eq("big_rst_vs", 32'(b_vs), 32'd0);
    check_eq("big_rst_active", 32'(b_act), 32'd0);
    check_eq("big_rst_pulses", 32'({b_ls, b_fs}), 32'd0);
    $display("big reset h=%0d v=%0d", b_h, b_v);

    // First tick lands on (0,0) with both pulses
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk); #1;
    check_eq("big_t1_horz", 32'(b_h), 32'd0);
    check_eq("big_t1_vert", 32'(b_v), 32'd0);
    check_eq("big_t1_fs", 32'(b_fs), 32'd1);
    check_eq("big_t1_ls", 32'(b_ls), 32'd1);
    check_eq("big_t1_active", 32'(b_act), 32'd1);
    check_eq("big_t1_hs", 32'(b_hs), 32'd0);
    check_eq("big_t1_vs", 32'(b_vs), 32'd0);
    $display("big first tick h=%0d v=%0d fs=%0b ls=%0b", b_h, b_v, b_fs, b_ls);

    // Rest of line 0: HS window, blanking width, line length
    hs_cnt = 0; hs_first = -1; hs_last = -1; inact_cnt = 0;
    for (int i = 1; i < 1688; i++) begin
      @(posedge clk); #1;
      if (b_hs === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(b_h);
        hs_last = int'(b_h);
      end
      if (b_act !== 1'b1) inact_cnt++;
    end
    check_eq("big_hs_width", 32'(hs_cnt), 32'd112);
    check_eq("big_hs_first", 32'(hs_first), 32'd1328);
    check_eq("big_hs_last", 32'(hs_last), 32'd1439);
    check_eq("big_blank_width", 32'(inact_cnt), 32'd408);
    check_eq("big_eol_horz", 32'(b_h), 32'd1687);
    check_eq("big_eol_vert", 32'(b_v), 32'd0);
    @(posedge clk); #1;
    check_eq("big_l1_horz", 32'(b_h), 32'd0);
    check_eq("big_l1_vert", 32'(b_v), 32'd1);
    check_eq("big_l1_ls", 32'(b_ls), 32'd1);
    check_eq("big_l1_fs", 32'(b_fs), 32'd0);
    $display("big line 1 start h=%0d v=%0d hs_width=%0d", b_h, b_v, hs_cnt);
    @(negedge clk);
    en_b = 1'b0;

    // Small geometry: reset, then PIX_EN continuously high for two frames
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    exp_period = SH_TOT * SV_TOT;
    for (int i = 0; i < 2 * SH_TOT * SV_TOT + 3; i++) step(1'b1, 1'b0);

    // PIX_EN every second clock
    last_fs = -1;
    exp_period = 2 * SH_TOT * SV_TOT;
    for (int i = 0; i < 2 * SH_TOT * SV_TOT + 5; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end

    // Reset mid-frame (RESET wins over PIX_EN), then restart
    exp_period = 0;
    for (int i = 0; i < 2 * SH_TOT * SV_TOT; i++) begin
      if (m_h == 12 && m_v == 4) break;
      step(1'b1, 1'b0);
    end
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);

    // Random PIX_EN pattern
    for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)), 1'b0);

    // Reset with PIX_EN low, hold, then restart
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
